// File: rtl/ninjakun_chrrom_arb_pkg.sv
// Shared encodings, widths and phase-to-owner map for the Ninjakun character-ROM arbiter.
// Build option: NINJAKUN_ARB_BORROW_EN lets an idle phase owner lend its slot.
package ninjakun_chrrom_arb_pkg;

  localparam int AD_W    = 13;
  localparam int ROMAD_W = 15;
  localparam int DT_W    = 32;
  localparam int NUM_SRC = 3;

  // Requester code, also the top two bits of the shared ROM address.
  typedef enum logic [1:0] {
    SRC_FG = 2'b00,
    SRC_BG = 2'b01,
    SRC_SP = 2'b10
  } src_e;

  // Sprites get two slots per round because they fetch the most words.
  function automatic src_e phase_owner(input logic [1:0] phase);
    case (phase)
      2'd0:    return SRC_FG;
      2'd1:    return SRC_BG;
      default: return SRC_SP;
    endcase
  endfunction

endpackage

// File: rtl/ninjakun_arb_slot.sv
// One requester's fetch slot: latches a request, waits for a grant, then
// captures the ROM word one cycle after the grant and pulses ack.
module ninjakun_arb_slot
  import ninjakun_chrrom_arb_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic [AD_W-1:0] ad_i,
  input  logic            grant_i,
  input  logic [DT_W-1:0] rom_dt_i,
  output logic            pend_o,
  output logic [AD_W-1:0] ad_o,
  output logic            ack_o,
  output logic [DT_W-1:0] dt_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PEND   = 2'd1;
  localparam logic [1:0] ST_FLIGHT = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [AD_W-1:0] ad_q, ad_d;
  logic [DT_W-1:0] dt_q, dt_d;
  logic            ack_q, ack_d;

  // The slot is already empty in the ack cycle, so a back-to-back request is taken.
  always_comb begin
    state_d = state_q;
    ad_d    = ad_q;
    dt_d    = dt_q;
    ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          state_d = ST_PEND;
          ad_d    = ad_i;
        end
      end
      ST_PEND: begin
        if (grant_i) begin
          state_d = ST_FLIGHT;
        end
      end
      ST_FLIGHT: begin
        state_d = ST_IDLE;
        dt_d    = rom_dt_i;
        ack_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ad_q    <= '0;
      dt_q    <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ad_q    <= ad_d;
      dt_q    <= dt_d;
      ack_q   <= ack_d;
    end
  end

  assign pend_o = (state_q == ST_PEND);
  assign ad_o   = ad_q;
  assign ack_o  = ack_q;
  assign dt_o   = dt_q;

endmodule

// File: rtl/ninjakun_chrrom_arb.sv
// Time-division arbiter sharing one synchronous tile ROM between FG, BG and SP fetchers.
// Build option: NINJAKUN_ARB_BORROW_EN (idle owner's slot goes to first pending of FG, BG, SP).
module ninjakun_chrrom_arb
  import ninjakun_chrrom_arb_pkg::*;
(
  input  logic               VCLKx4,
  input  logic               RESET,
  input  logic               FG_REQ,
  input  logic               BG_REQ,
  input  logic               SP_REQ,
  input  logic [AD_W-1:0]    FG_AD,
  input  logic [AD_W-1:0]    BG_AD,
  input  logic [AD_W-1:0]    SP_AD,
  output logic               FG_ACK,
  output logic               BG_ACK,
  output logic               SP_ACK,
  output logic [DT_W-1:0]    FG_DT,
  output logic [DT_W-1:0]    BG_DT,
  output logic [DT_W-1:0]    SP_DT,
  output logic [ROMAD_W-1:0] ROMAD,
  input  logic [DT_W-1:0]    ROMDT,
  input  logic               ROMEN,
  output logic [1:0]         PHASE
);

  logic [1:0]         phase_q, phase_d;
  logic [ROMAD_W-1:0] romad_q, romad_d;

  logic [NUM_SRC-1:0] req_v, pend_v, grant_v, ack_v;
  logic [AD_W-1:0]    ad_in   [NUM_SRC];
  logic [AD_W-1:0]    ad_slot [NUM_SRC];
  logic [DT_W-1:0]    dt_v    [NUM_SRC];

  src_e owner;
  src_e grant_src;

  assign req_v    = {SP_REQ, BG_REQ, FG_REQ};
  assign ad_in[0] = FG_AD;
  assign ad_in[1] = BG_AD;
  assign ad_in[2] = SP_AD;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
      ninjakun_arb_slot u_slot (
        .clk_i    (VCLKx4),
        .rst_i    (RESET),
        .req_i    (req_v[gi]),
        .ad_i     (ad_in[gi]),
        .grant_i  (grant_v[gi]),
        .rom_dt_i (ROMDT),
        .pend_o   (pend_v[gi]),
        .ad_o     (ad_slot[gi]),
        .ack_o    (ack_v[gi]),
        .dt_o     (dt_v[gi])
      );
    end
  endgenerate

  always_comb begin
    owner     = phase_owner(phase_q);
    grant_v   = '0;
    grant_src = owner;
    if (!ROMEN) begin
      if (pend_v[owner]) begin
        grant_v[owner] = 1'b1;
      end
`ifdef NINJAKUN_ARB_BORROW_EN
      else begin
        // Descending scan so the lowest-numbered pending requester wins.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
          if (pend_v[i] && (i != int'(owner))) begin
            grant_v    = '0;
            grant_v[i] = 1'b1;
            grant_src  = src_e'(2'(i));
          end
        end
      end
`endif
    end
  end

  // ROMAD is combinational in the grant cycle so the ROM sees it one edge later.
  always_comb begin
    phase_d = phase_q + 2'd1;
    romad_d = romad_q;
    if (|grant_v) begin
      romad_d = {grant_src, ad_slot[grant_src]};
    end
  end

  always_ff @(posedge VCLKx4 or posedge RESET) begin
    if (RESET) begin
      phase_q <= 2'd0;
      romad_q <= '0;
    end else begin
      phase_q <= phase_d;
      romad_q <= romad_d;
    end
  end

  assign ROMAD  = romad_d;
  assign PHASE  = phase_q;
  assign FG_ACK = ack_v[0];
  assign BG_ACK = ack_v[1];
  assign SP_ACK = ack_v[2];
  assign FG_DT  = dt_v[0];
  assign BG_DT  = dt_v[1];
  assign SP_DT  = dt_v[2];

endmodule

// File: doc/ninjakun_chrrom_arb.md
NINJAKUN_CHRROM_ARB -- requirements
Module: ninjakun_chrrom_arb

Interface
REQ-001 SHALL have port VCLKx4  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port RESET  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports FG_REQ, BG_REQ, SP_REQ  in  1 each  single-cycle fetch request pulses.
REQ-004 SHALL have ports FG_AD, BG_AD, SP_AD  in  13 each  tile-ROM word address, sampled in the cycle its REQ is high.
REQ-005 SHALL have ports FG_ACK, BG_ACK, SP_ACK  out  1 each  single-cycle pulses marking valid return data.
REQ-006 SHALL have ports FG_DT, BG_DT, SP_DT  out  32 each  returned data, held until that requester's next ACK.
REQ-007 SHALL have port ROMAD  out  15  shared ROM address {SRC[1:0],AD[12:0]}; FG=00, BG=01, SP=10.
REQ-008 SHALL have port ROMDT  in  32  shared ROM data; synchronous ROM with 1-cycle read latency.
REQ-009 SHALL have port ROMEN  in  1  ROM download active; blocks all issues.
REQ-010 SHALL have port PHASE  out  2  free-running slot counter.

Function
REQ-011 PHASE SHALL increment by 1 every cycle and wrap 3->0.
REQ-012 Each requester SHALL own one pending slot (valid bit + 13-bit address); REQ with slot empty loads it.
REQ-013 REQ while that requester's slot is pending or in flight SHALL be ignored; the stored address is unchanged.
REQ-014 Slot owners: PHASE 0 = FG, PHASE 1 = BG, PHASE 2 and 3 = SP.
REQ-015 In cycle t the phase owner, if pending and ROMEN low, SHALL be granted: ROMAD driven from its slot, slot marked in flight.
REQ-016 ROMDT SHALL be captured into the granted requester's DT register at the end of cycle t+1, with its ACK high in cycle t+2; its slot clears in cycle t+2.
REQ-017 REQ in the ACK cycle of the same requester SHALL be accepted (the slot is empty from that cycle on).
REQ-018 At most one grant per cycle; issue throughput is one read per cycle.
REQ-019 ROMEN high in cycle t SHALL suppress grants in cycle t; pending slots are held; an access granted before ROMEN rose SHALL still complete and ACK.
REQ-020 When there is no grant, ROMAD SHALL hold its previous value.
REQ-021 A REQ arriving in the same cycle as its owning phase SHALL NOT be granted until that owner's next slot.

Reset
REQ-022 While RESET is high: PHASE=0, all slots and in-flight flags clear, ACKs=0, DTs=0, ROMAD=0.
REQ-023 Reset asserted mid-access SHALL drop the access with no ACK after release; the first cycle after release is PHASE 0.

Configuration
REQ-024 Macro NINJAKUN_ARB_BORROW_EN defined: if the phase owner is idle, the slot SHALL go to the first pending requester in the order FG, BG, SP (skipping the owner).
REQ-025 NINJAKUN_ARB_BORROW_EN undefined: strict TDM; an idle owner's slot SHALL go unused.

Structure
REQ-026 A shared package SHALL hold the SRC encodings (FG/BG/SP), the 13/15/32 widths and the phase-to-owner map.
REQ-027 One sub-module, ninjakun_arb_slot (pending/in-flight register per requester), SHALL be instantiated three times.

Verification
REQ-028 FG_REQ with FG_AD=0x0123, issued so that the next cycle is PHASE 0 -> ROMAD=0x0123 at PHASE 0; FG_ACK 2 cycles later with FG_DT = ROM word 0x0123.
REQ-029 FG, BG and SP all request 0x1FFF in the same cycle (PHASE 3) -> ROMAD sequence 0x1FFF, 0x3FFF, 0x5FFF; ACKs in order FG, BG, SP.
REQ-030 SP_REQ 0x0040 then SP_REQ 0x0041 one cycle later -> only 0x4040 issued; second request ignored; a single SP_ACK.
REQ-031 ROMEN high for 8 cycles with BG pending -> no grants in that window; BG granted at the first PHASE 1 after ROMEN falls.
REQ-032 Borrow: FG idle, SP pending at PHASE 0 -> with the macro, SP granted at PHASE 0; without it, SP granted at PHASE 2.
REQ-033 RESET pulse in the cycle after a BG grant -> no BG_ACK; all outputs 0; PHASE=0 in the first cycle after release.
